cache_axi_bridge: RTL and testbench

AXI3 master bridge that sits directly downstream of the cache read/write arbiter. It converts the arbiter's simple request/ready/return protocol into independent AXI read and write transactions on a 32-bit AXI bus. Cache-line (8-word) transfers are converted into INCR bursts; uncached byte, half and word accesses are converted into single beats. Read data streams back beat-by-beat as ret_valid/ret_last/ret_data, and write completion is reported as a one-cycle wr_resp pulse.

---
 rtl/cache_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache arbiter to AXI3 master bridge (line bursts, single beats)
// Optional read-after-write line hold-off is enabled by defining AXI_BRIDGE_RAW_CHECK_EN.
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req_i,
  input  logic [2:0]   rd_type_i,
  input  logic [31:0]  rd_addr_i,
  output logic         rd_rdy_o,
  output logic         ret_valid_o,
  output logic         ret_last_o,
  output logic [31:0]  ret_data_o,
  input  logic         wr_req_i,
  input  logic [2:0]   wr_type_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [3:0]   wr_wstrb_i,
  input  logic [255:0] wr_data_i,
  output logic         wr_rdy_o,
  output logic         wr_resp_o,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t     r_state, r_next;
  w_state_t     w_state, w_next;
  logic         hazard;
  logic         rd_accept;
  logic         wr_accept;
  logic [255:0] wr_buf;
  logic [2:0]   wr_cnt;
  logic         unused_axi_fields;

  assign arid  = RD_ID;
  assign awid  = WR_ID;
  assign wid   = WR_ID;
  assign wdata = wr_buf[31:0];

  assign rd_accept = rd_req_i & rd_rdy_o;
  assign wr_accept = wr_req_i & wr_rdy_o;

  // Response IDs and codes carry no information for this single-ID master.
  assign unused_axi_fields = ^{rid, rresp, bid, bresp};

`ifdef AXI_BRIDGE_RAW_CHECK_EN
  // Hold a read off while a write to the same 32-byte line is still in flight.
  assign hazard = (w_state != W_IDLE) && (rd_addr_i[31:5] == awaddr[31:5]);
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  always_comb begin
    r_next      = r_state;
    rd_rdy_o    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    ret_valid_o = 1'b0;
    ret_last_o  = 1'b0;
    ret_data_o  = 32'd0;
    case (r_state)
      R_IDLE: begin
        rd_rdy_o = ~hazard;
        if (rd_req_i && !hazard) r_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready      = 1'b1;
        ret_valid_o = rvalid;
        ret_last_o  = rvalid & rlast;
        ret_data_o  = rdata;
        if (rvalid && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr  <= 32'd0;
      arlen   <= 8'd0;
      arsize  <= 3'd0;
      arburst <= 2'b00;
    end else if (rd_accept) begin
      araddr  <= rd_addr_i;
      arlen   <= (rd_type_i == 3'b100) ? 8'd7 : 8'd0;
      arsize  <= (rd_type_i == 3'b100) ? 3'd2 : {1'b0, rd_type_i[1:0]};
      arburst <= 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  always_comb begin
    w_next   = w_state;
    wr_rdy_o = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_rdy_o = 1'b1;
        if (wr_req_i) w_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (wr_cnt == awlen[2:0]);
        if (wready && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // The line is streamed out of a shift buffer so W data always comes from bits [31:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr    <= 32'd0;
      awlen     <= 8'd0;
      awsize    <= 3'd0;
      awburst   <= 2'b00;
      wstrb     <= 4'h0;
      wr_buf    <= 256'd0;
      wr_cnt    <= 3'd0;
      wr_resp_o <= 1'b0;
    end else begin
      wr_resp_o <= (w_state == W_RESP) && bvalid;
      if (wr_accept) begin
        awaddr  <= wr_addr_i;
        awlen   <= (wr_type_i == 3'b100) ? 8'd7 : 8'd0;
        awsize  <= (wr_type_i == 3'b100) ? 3'd2 : {1'b0, wr_type_i[1:0]};
        awburst <= 2'b01;
        wstrb   <= (wr_type_i == 3'b100) ? 4'hF : wr_wstrb_i;
        wr_buf  <= wr_data_i;
        wr_cnt  <= 3'd0;
      end else if ((w_state == W_DATA) && wready) begin
        wr_buf <= {32'd0, wr_buf[255:32]};
        wr_cnt <= wr_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - self-checking bench for cache_axi_bridge
// Transaction-level model checked every cycle, plus directed literal expectations.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req_i;
  logic [2:0]   rd_type_i;
  logic [31:0]  rd_addr_i;
  logic         rd_rdy_o, ret_valid_o, ret_last_o;
  logic [31:0]  ret_data_o;
  logic         wr_req_i;
  logic [2:0]   wr_type_i;
  logic [31:0]  wr_addr_i;
  logic [3:0]   wr_wstrb_i;
  logic [255:0] wr_data_i;
  logic         wr_rdy_o, wr_resp_o;
  logic [3:0]   arid, awid, wid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  always #5 clk = ~clk;

  cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .rd_req_i(rd_req_i), .rd_type_i(rd_type_i), .rd_addr_i(rd_addr_i), .rd_rdy_o(rd_rdy_o),
    .ret_valid_o(ret_valid_o), .ret_last_o(ret_last_o), .ret_data_o(ret_data_o),
    .wr_req_i(wr_req_i), .wr_type_i(wr_type_i), .wr_addr_i(wr_addr_i), .wr_wstrb_i(wr_wstrb_i),
    .wr_data_i(wr_data_i), .wr_rdy_o(wr_rdy_o), .wr_resp_o(wr_resp_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  // Model state: one outstanding read and one outstanding write, tracked by phase.
  bit          model_on;
  bit          rd_busy, ar_done, wr_busy, aw_done, resp_pulse;
  logic [31:0] m_araddr, m_awaddr;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  wbeat_t      w_q[$];
  logic [31:0] r_q[$];
  int          r_beats, w_beats, cyc;
  bit          e_rd_rdy, e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready, haz, pulse_next;
  wbeat_t      nb;

  // Knobs written only by the stimulus process.
  logic [31:0] rd_base;
  int          hold_r, hold_w;

  // Logs of what the DUT actually put on the bus, written only by the monitor.
  logic [31:0] ar_addr_log[$], aw_addr_log[$], ret_data_log[$], w_data_log[$];
  logic [7:0]  ar_len_log[$], aw_len_log[$];
  logic [2:0]  ar_size_log[$], aw_size_log[$];
  logic [1:0]  ar_burst_log[$];
  logic [3:0]  w_strb_log[$];
  bit          ret_last_log[$], w_last_log[$];
  int          resp_cnt;

  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = 0;
    bvalid = 0; rid = 4'd0; rresp = 2'b00; bid = 4'd1; bresp = 2'b00;
    model_on = 0; rd_busy = 0; ar_done = 0; wr_busy = 0; aw_done = 0; resp_pulse = 0;
    r_beats = 0; w_beats = 0; cyc = 0; resp_cnt = 0;
    forever begin
      @(negedge clk);
      haz = 1'b0;
`ifdef AXI_BRIDGE_RAW_CHECK_EN
      haz = wr_busy && (rd_addr_i[31:5] == m_awaddr[31:5]);
`endif
      e_rd_rdy  = !rd_busy && !haz;
      e_arvalid = rd_busy && !ar_done;
      e_rready  = rd_busy && ar_done;
      e_awvalid = wr_busy && !aw_done;
      e_wvalid  = wr_busy && aw_done && (w_q.size() > 0);
      e_bready  = wr_busy && aw_done && (w_q.size() == 0);
      if (model_on) begin
        chk("rd_rdy", rd_rdy_o, e_rd_rdy);
        chk("wr_rdy", wr_rdy_o, !wr_busy);
        chk("arvalid", arvalid, e_arvalid);
        chk("rready", rready, e_rready);
        chk("awvalid", awvalid, e_awvalid);
        chk("wvalid", wvalid, e_wvalid);
        chk("bready", bready, e_bready);
        chk("ret_valid", ret_valid_o, e_rready && rvalid);
        chk("ret_last", ret_last_o, e_rready && rvalid && rlast);
        chk("wr_resp", wr_resp_o, resp_pulse);
        chk("ids", {arid, awid, wid}, 12'h011);
        if (e_rready && rvalid) chk("ret_data", ret_data_o, rdata);
        if (e_arvalid) chk("ar_fields", {araddr, arlen, arsize, arburst}, {m_araddr, m_arlen, m_arsize, 2'b01});
        if (e_awvalid) chk("aw_fields", {awaddr, awlen, awsize, awburst}, {m_awaddr, m_awlen, m_awsize, 2'b01});
        if (e_wvalid) chk("w_beat", {wdata, wstrb, wlast}, w_q[0]);
      end
      if (arvalid && arready) begin
        ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
        ar_size_log.push_back(arsize); ar_burst_log.push_back(arburst);
      end
      if (awvalid && awready) begin
        aw_addr_log.push_back(awaddr); aw_len_log.push_back(awlen); aw_size_log.push_back(awsize);
      end
      if (wvalid && wready) begin
        w_data_log.push_back(wdata); w_strb_log.push_back(wstrb); w_last_log.push_back(wlast);
      end
      if (ret_valid_o) begin
        ret_data_log.push_back(ret_data_o); ret_last_log.push_back(ret_last_o);
      end
      if (wr_resp_o) resp_cnt++;
      // Advance the model by what happens at the coming rising edge.
      if (e_arvalid && arready) begin
        ar_done = 1;
        for (int i = 0; i <= int'(m_arlen); i++) r_q.push_back(rd_base + i);
      end
      if (e_rready && rvalid) begin
        void'(r_q.pop_front());
        r_beats++;
        if (rlast) rd_busy = 0;
      end
      if (rd_req_i && e_rd_rdy) begin
        rd_busy = 1; ar_done = 0; r_beats = 0;
        m_araddr = rd_addr_i;
        m_arlen  = (rd_type_i == 3'b100) ? 8'd7 : 8'd0;
        m_arsize = (rd_type_i == 3'b100) ? 3'd2 : {1'b0, rd_type_i[1:0]};
      end
      pulse_next = 0;
      if (e_awvalid && awready) aw_done = 1;
      if (e_wvalid && wready) begin
        void'(w_q.pop_front());
        w_beats++;
      end
      if (e_bready && bvalid) begin
        wr_busy = 0; pulse_next = 1;
      end
      if (wr_req_i && !wr_busy) begin
        wr_busy = 1; aw_done = 0; w_beats = 0;
        m_awaddr = wr_addr_i;
        m_awlen  = (wr_type_i == 3'b100) ? 8'd7 : 8'd0;
        m_awsize = (wr_type_i == 3'b100) ? 3'd2 : {1'b0, wr_type_i[1:0]};
        w_q.delete();
        if (wr_type_i == 3'b100) begin
          for (int i = 0; i < 8; i++) begin
            nb.data = wr_data_i[32*i +: 32]; nb.strb = 4'hF; nb.last = (i == 7);
            w_q.push_back(nb);
          end
        end else begin
          nb.data = wr_data_i[31:0]; nb.strb = wr_wstrb_i; nb.last = 1'b1;
          w_q.push_back(nb);
        end
      end
      resp_pulse = pulse_next;
      if (reset) begin
        rd_busy = 0; ar_done = 0; wr_busy = 0; aw_done = 0; resp_pulse = 0;
        r_q.delete(); w_q.delete(); model_on = 1;
      end
      // Slave side: drive the new cycle's responses just after the edge.
      @(posedge clk);
      #1;
      cyc++;
      arready = (cyc % 3) != 0;
      awready = (cyc % 2) == 0;
      wready  = ((cyc % 2) == 1) && (w_beats < hold_w);
      rvalid  = (r_q.size() > 0) && ((cyc % 3) != 1) && (r_beats < hold_r);
      rdata   = 32'hDEADBEEF;
      rlast   = 1'b0;
      if (rvalid) begin
        rdata = r_q[0];
        rlast = (r_q.size() == 1);
      end
      bvalid = wr_busy && aw_done && (w_q.size() == 0) && ((cyc % 2) == 1);
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [2:0] t);
    int n;
    rd_addr_i = a; rd_type_i = t; rd_req_i = 1;
    n = 0;
    @(negedge clk);
    while (!rd_rdy_o && n < 200) begin n++; @(negedge clk); end
    chk("rd_accept_timeout", rd_rdy_o, 1);
    @(posedge clk); #1;
    rd_req_i = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [255:0] d);
    int n;
    wr_addr_i = a; wr_type_i = t; wr_wstrb_i = s; wr_data_i = d; wr_req_i = 1;
    n = 0;
    @(negedge clk);
    while (!wr_rdy_o && n < 200) begin n++; @(negedge clk); end
    chk("wr_accept_timeout", wr_rdy_o, 1);
    @(posedge clk); #1;
    wr_req_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rd_rdy_o && wr_rdy_o) && n < 400) begin n++; @(negedge clk); end
    chk(name, rd_rdy_o && wr_rdy_o, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_ret_last(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ret_last_o && n < 300) begin n++; @(negedge clk); end
    chk(name, ret_last_o, 1);
  endtask

  function automatic logic [255:0] line_data();
    logic [255:0] d;
    logic [31:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = 32'h11111111 * (i + 1);
      d[32*i +: 32] = w;
    end
    return d;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rb, ab, wb, awb, respb, n;
    logic [31:0] ew;
    reset = 1; rd_req_i = 0; rd_type_i = 0; rd_addr_i = 0;
    wr_req_i = 0; wr_type_i = 0; wr_addr_i = 0; wr_wstrb_i = 0; wr_data_i = 0;
    rd_base = 0; hold_r = 99; hold_w = 99;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid_o, wr_resp_o}, 8'h00);
    chk("rst_rdys", {rd_rdy_o, wr_rdy_o}, 2'b11);
    chk("rst_payload", {araddr, arlen, awaddr, awlen, wstrb}, 84'd0);
    chk("rst_ids", {arid, awid, wid}, 12'h011);
    @(posedge clk); #1;

    // Line read with rvalid gaps.
    rb = ret_data_log.size(); ab = ar_addr_log.size(); rd_base = 32'h0;
    do_read(32'h1FC0_0020, 3'b100);
    wait_ret_last("line_rd_last_seen");
    @(negedge clk);
    chk("line_rd_rdy_after", rd_rdy_o, 1);
    chk("line_rd_beats", ret_data_log.size() - rb, 8);
    if (ret_data_log.size() - rb == 8)
      for (int i = 0; i < 8; i++) begin
        chk("line_rd_data", ret_data_log[rb+i], i);
        chk("line_rd_last", ret_last_log[rb+i], i == 7);
      end
    chk("line_ar_count", ar_addr_log.size() - ab, 1);
    if (ar_addr_log.size() > ab)
      chk("line_ar", {ar_addr_log[ab], ar_len_log[ab], ar_size_log[ab], ar_burst_log[ab]},
          {32'h1FC00020, 8'd7, 3'd2, 2'b01});
    wait_idle("line_rd_idle");

    // Uncached byte read.
    rb = ret_data_log.size(); ab = ar_addr_log.size(); rd_base = 32'h5A;
    do_read(32'h8000_0003, 3'b000);
    wait_ret_last("byte_rd_last_seen");
    wait_idle("byte_rd_idle");
    chk("byte_rd_beats", ret_data_log.size() - rb, 1);
    if (ret_data_log.size() > rb) chk("byte_rd_ret", {ret_data_log[rb], ret_last_log[rb]}, {32'h5A, 1'b1});
    if (ar_addr_log.size() > ab)
      chk("byte_ar", {ar_addr_log[ab], ar_len_log[ab], ar_size_log[ab]}, {32'h80000003, 8'd0, 3'd0});

    // Line write with toggling wready.
    wb = w_data_log.size(); awb = aw_addr_log.size(); respb = resp_cnt;
    do_write(32'h2000_0100, 3'b100, 4'h0, line_data());
    wait_idle("line_wr_idle");
    chk("line_wr_beats", w_data_log.size() - wb, 8);
    if (w_data_log.size() - wb == 8)
      for (int i = 0; i < 8; i++) begin
        ew = 32'h11111111 * (i + 1);
        chk("line_wr_beat", {w_data_log[wb+i], w_strb_log[wb+i], w_last_log[wb+i]}, {ew, 4'hF, i == 7});
      end
    if (aw_addr_log.size() > awb)
      chk("line_aw", {aw_addr_log[awb], aw_len_log[awb], aw_size_log[awb]}, {32'h20000100, 8'd7, 3'd2});
    chk("line_wr_resp", resp_cnt - respb, 1);

    // Word write with partial strobe.
    wb = w_data_log.size(); awb = aw_addr_log.size(); respb = resp_cnt;
    do_write(32'h3000_0008, 3'b010, 4'b0110, {224'd0, 32'hCAFEBABE});
    wait_idle("word_wr_idle");
    chk("word_wr_beats", w_data_log.size() - wb, 1);
    if (w_data_log.size() > wb)
      chk("word_wr_beat", {w_data_log[wb], w_strb_log[wb], w_last_log[wb]}, {32'hCAFEBABE, 4'b0110, 1'b1});
    if (aw_addr_log.size() > awb)
      chk("word_aw", {aw_len_log[awb], aw_size_log[awb]}, {8'd0, 3'd2});
    chk("word_wr_resp", resp_cnt - respb, 1);

    // Read to the line of an in-flight write.
    hold_w = 0; rd_base = 32'h77;
    do_write(32'h0000_1040, 3'b100, 4'h0, line_data());
    rd_addr_i = 32'h0000_1044; rd_type_i = 3'b010; rd_req_i = 1;
`ifdef AXI_BRIDGE_RAW_CHECK_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("raw_held", rd_rdy_o, 0);
    end
    hold_w = 99;
    n = 0;
    @(negedge clk);
    while (!wr_resp_o && n < 300) begin n++; @(negedge clk); end
    chk("raw_resp_seen", wr_resp_o, 1);
    chk("raw_rdy_at_resp", rd_rdy_o, 1);
`else
    @(negedge clk);
    chk("raw_off_accept", rd_rdy_o, 1);
    hold_w = 99;
`endif
    @(posedge clk); #1;
    rd_req_i = 0;
    wait_idle("raw_idle");

    // Read and write to the same line presented together from idle.
    rd_addr_i = 32'h5000_0004; rd_type_i = 3'b010; rd_req_i = 1;
    wr_addr_i = 32'h5000_0000; wr_type_i = 3'b100; wr_data_i = line_data(); wr_req_i = 1;
    @(negedge clk);
    chk("same_cycle_rdys", {rd_rdy_o, wr_rdy_o}, 2'b11);
    @(posedge clk); #1;
    rd_req_i = 0; wr_req_i = 0;
    wait_idle("same_cycle_idle");

    // Reset in the middle of both bursts.
    hold_r = 2; hold_w = 3; rd_base = 32'h40;
    rd_addr_i = 32'h6000_0000; rd_type_i = 3'b100; rd_req_i = 1;
    wr_addr_i = 32'h7000_0000; wr_type_i = 3'b100; wr_data_i = line_data(); wr_req_i = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rd_req_i = 0; wr_req_i = 0;
    n = 0;
    @(negedge clk);
    while (!(r_beats == 2 && w_beats == 3) && n < 300) begin n++; @(negedge clk); end
    chk("rst_mid_reached", (r_beats == 2) && (w_beats == 3), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; hold_r = 99; hold_w = 99;
    @(negedge clk);
    chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready, ret_valid_o, wr_resp_o}, 7'h00);
    chk("rst_mid_rdys", {rd_rdy_o, wr_rdy_o}, 2'b11);
    @(posedge clk); #1;
    rb = ret_data_log.size(); rd_base = 32'h100;
    do_read(32'h0000_0200, 3'b100);
    wait_ret_last("post_rst_last_seen");
    wait_idle("post_rst_idle");
    chk("post_rst_beats", ret_data_log.size() - rb, 8);
    if (ret_data_log.size() - rb == 8)
      chk("post_rst_final", {ret_data_log[rb+7], ret_last_log[rb+7]}, {32'h107, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
